// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared microcontroller constants: instruction width, opcodes, fetch states
package mcu_pkg;

    localparam int INSTR_W = 12;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_STO  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JMPZ = 4'h9;
    localparam logic [3:0] OP_JMPO = 4'hA;
    localparam logic [3:0] OP_SEI  = 4'hC;
    localparam logic [3:0] OP_INVB = 4'hD;
    localparam logic [3:0] OP_CALL = 4'hE;
    localparam logic [3:0] OP_RET  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LATCH = 2'd2,
        ST_EXEC  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: program counter, ROM read, opcode/operand issue
//
// Ports:
//   clock, reset_n       - system clock, asynchronous active-low reset
//   run                  - level, enables fetching; 0 parks in IDLE after current instruction
//   stall                - level, holds the issued instruction in EXEC
//   pc_load/value        - one-cycle redirect from the control unit; beats everything
//   rom_en/addr/data     - synchronous program ROM port (data one cycle after enable)
//   command, data        - opcode / operand, NOP/zero outside EXEC
//   instr_valid          - command/data carry a live instruction
//   pc_ret               - pc+1, return address for call/interrupt
module fetch_unit
    import mcu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int OP_W   = 4,
    parameter int ARG_W  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              run,
    input  logic              stall,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_value,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [OP_W+ARG_W-1:0] rom_data,
    output logic [OP_W-1:0]   command,
    output logic [ARG_W-1:0]  data,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_ret
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q;
    logic [OP_W-1:0]   cmd_q, cmd_d;
    logic [ARG_W-1:0]  arg_q, arg_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            cmd_q   <= '0;
            arg_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cmd_q   <= cmd_d;
            arg_q   <= arg_d;
            // Remember the last issued address so rom_addr holds while the ROM is idle.
            if (state_q == ST_FETCH) begin
                addr_q <= pc_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cmd_d   = cmd_q;
        arg_d   = arg_q;
        if (pc_load) begin
            // Redirect wins over stall and drops any word captured or in flight.
            pc_d    = pc_load_value;
            cmd_d   = '0;
            arg_d   = '0;
            state_d = run ? ST_FETCH : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_LATCH;
                end
                ST_LATCH: begin
                    cmd_d   = rom_data[OP_W+ARG_W-1:ARG_W];
                    arg_d   = rom_data[ARG_W-1:0];
                    state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    if (!stall) begin
                        pc_d    = pc_q + PC_ONE;
                        state_d = run ? ST_FETCH : ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign rom_en      = (state_q == ST_FETCH);
    assign rom_addr    = rom_en ? pc_q : addr_q;
    assign instr_valid = (state_q == ST_EXEC);
    assign command     = instr_valid ? cmd_q : OP_NOP[OP_W-1:0];
    assign data        = instr_valid ? arg_q : '0;
    assign pc_ret      = pc_q + PC_ONE;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        run;
    logic        stall;
    logic        pc_load;
    logic [7:0]  pc_load_value;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [11:0] rom_data;
    logic [3:0]  command;
    logic [7:0]  data;
    logic        instr_valid;
    logic [7:0]  pc_ret;

    logic [11:0] mem [256];

    int n_vec = 0;
    int n_bad = 0;

    fetch_unit #(.ADDR_W(8), .OP_W(4), .ARG_W(8)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .run          (run),
        .stall        (stall),
        .pc_load      (pc_load),
        .pc_load_value(pc_load_value),
        .rom_en       (rom_en),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .command      (command),
        .data         (data),
        .instr_valid  (instr_valid),
        .pc_ret       (pc_ret)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (rom_en) rom_data <= mem[rom_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_exec(input string tag, input logic [3:0] c, input logic [7:0] d, input logic [7:0] r);
        chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
        chk({tag, ".cmd"}, 32'(command), 32'(c));
        chk({tag, ".data"}, 32'(data), 32'(d));
        chk({tag, ".pc_ret"}, 32'(pc_ret), 32'(r));
        chk({tag, ".rom_en"}, 32'(rom_en), 32'd0);
    endtask

    task automatic chk_fetch(input string tag, input logic [7:0] a);
        chk({tag, ".rom_en"}, 32'(rom_en), 32'd1);
        chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(a));
        chk({tag, ".valid"}, 32'(instr_valid), 32'd0);
        chk({tag, ".cmd"}, 32'(command), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".rom_en"}, 32'(rom_en), 32'd0);
        chk({tag, ".rom_addr"}, 32'(rom_addr), 32'h00);
        chk({tag, ".cmd"}, 32'(command), 32'h0);
        chk({tag, ".data"}, 32'(data), 32'h00);
        chk({tag, ".valid"}, 32'(instr_valid), 32'd0);
        chk({tag, ".pc_ret"}, 32'(pc_ret), 32'h01);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 12'h100 | 12'(i);
        mem[8'h00] = 12'h805;
        mem[8'h01] = 12'h7AA;
        mem[8'h40] = 12'hC33;
        mem[8'hFF] = 12'h000;

        reset_n = 1'b0; run = 1'b0; stall = 1'b0; pc_load = 1'b0; pc_load_value = 8'h00;
        step(); step();
        chk_reset("reset");
        reset_n = 1'b1; run = 1'b1;

        // Plain fetch of ROM[0] and ROM[1]: issue in cycles 3 and 6.
        step(); chk_fetch("f0", 8'h00);
        step(); chk("l0.valid", 32'(instr_valid), 32'd0);
        step(); chk_exec("e0", 4'h8, 8'h05, 8'h01);
        step(); chk_fetch("f1", 8'h01);
        step(); chk("l1.valid", 32'(instr_valid), 32'd0);
        step(); chk_exec("e1", 4'h7, 8'hAA, 8'h02);

        // Redirect in the FETCH following EXEC aborts fetch of 02.
        step(); chk_fetch("f2", 8'h02);
        pc_load = 1'b1; pc_load_value = 8'h40;
        step(); chk_fetch("f40", 8'h40);
        pc_load = 1'b0;
        step(); chk("l40.valid", 32'(instr_valid), 32'd0);
        step(); chk_exec("e40", 4'hC, 8'h33, 8'h41);

        // Stall four cycles, then a load arriving while stalled wins.
        stall = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(); chk_exec("stall", 4'hC, 8'h33, 8'h41);
        end
        pc_load = 1'b1; pc_load_value = 8'h10;
        step(); chk_fetch("f10", 8'h10);
        chk("f10.pc_ret", 32'(pc_ret), 32'h11);
        pc_load = 1'b0; stall = 1'b0;
        step();
        step(); chk_exec("e10", 4'h1, 8'h10, 8'h11);

        // Wrap: pc FF issues NOP with pc_ret 00, next fetch from 00.
        step(); chk_fetch("f11", 8'h11);
        pc_load = 1'b1; pc_load_value = 8'hFF;
        step(); chk_fetch("fFF", 8'hFF);
        pc_load = 1'b0;
        step();
        step(); chk_exec("eFF", 4'h0, 8'h00, 8'h00);
        run = 1'b0;

        // run dropped in EXEC: pc increments, unit parks, rom_addr holds.
        step();
        chk("idle.rom_en", 32'(rom_en), 32'd0);
        chk("idle.rom_addr", 32'(rom_addr), 32'hFF);
        chk("idle.pc_ret", 32'(pc_ret), 32'h01);
        chk("idle.valid", 32'(instr_valid), 32'd0);
        step(); chk("idle2.rom_en", 32'(rom_en), 32'd0);
        run = 1'b1;
        step(); chk_fetch("fwrap", 8'h00);
        step();
        step(); chk_exec("ewrap", 4'h8, 8'h05, 8'h01);
        run = 1'b0;
        step(); chk("idle3.pc_ret", 32'(pc_ret), 32'h02);

        // Load while parked: pc moves, unit stays idle.
        pc_load = 1'b1; pc_load_value = 8'h20;
        step();
        chk("idleload.rom_en", 32'(rom_en), 32'd0);
        chk("idleload.pc_ret", 32'(pc_ret), 32'h21);
        pc_load = 1'b0; run = 1'b1;
        step(); chk_fetch("f20", 8'h20);
        step(); chk("l20.rom_addr", 32'(rom_addr), 32'h20);

        // Asynchronous reset in LATCH.
        #2 reset_n = 1'b0;
        #1 chk_reset("async");
        step();
        reset_n = 1'b1;
        step(); chk_fetch("frst", 8'h00);
        step();
        step(); chk_exec("erst", 4'h8, 8'h05, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
